tage_update_queue: RTL

// - Producer side of the TAGE update interface. Captures per-branch prediction metadata at fetch

---
 rtl/tage_update_queue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tage_update_queue.sv
// tage_update_queue: holds TAGE prediction metadata from fetch until execute resolves each branch,
// then drains one update packet per cycle in program order. Build option: TAGE_UPDATE_QUEUE_BYPASS_EN.
module tage_update_queue #(
  parameter int DEPTH      = 8,
  parameter int VLEN       = 39,
  parameter int HIST_BITS  = 64,
  parameter int PHIST_BITS = 16,
  parameter int N_TABLES   = 4,
  localparam int ID_BITS   = $clog2(N_TABLES),
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int M         = 4 + 2 * ID_BITS + N_TABLES,
  localparam int U         = VLEN + HIST_BITS + PHIST_BITS + 6 + 2 * ID_BITS + N_TABLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [VLEN-1:0]       push_pc_i,
  input  logic [HIST_BITS-1:0]  push_ghist_i,
  input  logic [PHIST_BITS-1:0] push_phist_i,
  input  logic [M-1:0]          push_meta_i,
  output logic [IDX_W-1:0]      push_idx_o,
  input  logic                  resolve_valid_i,
  input  logic [IDX_W-1:0]      resolve_idx_i,
  input  logic                  resolve_taken_i,
  input  logic                  resolve_mispred_i,
  output logic                  update_valid_o,
  output logic [U-1:0]          update_o,
  output logic [IDX_W:0]        count_o
);

  typedef struct packed {
    logic [VLEN-1:0]       pc;
    logic                  taken;
    logic [HIST_BITS-1:0]  ghist;
    logic [PHIST_BITS-1:0] phist;
    logic                  pred_taken;
    logic                  provider_taken;
    logic                  alt_taken;
    logic [ID_BITS-1:0]    pred_id;
    logic [ID_BITS-1:0]    alt_id;
    logic [N_TABLES-1:0]   u_is_null;
    logic                  mispredict;
    logic                  pseudo_new_alloc;
  } tage_update_t;

  localparam logic [IDX_W:0] PTR_ONE = (IDX_W + 1)'(1);

  logic [IDX_W:0]        head_q, tail_q, tail_next, mispred_tail;
  logic [IDX_W-1:0]      head_idx, tail_idx, res_off;
  logic [DEPTH-1:0]      alloc_q, alloc_next, resolved_q, resolved_next, younger;
  logic [DEPTH-1:0]      taken_q, mispred_q;
  logic [VLEN-1:0]       pc_q    [DEPTH];
  logic [HIST_BITS-1:0]  ghist_q [DEPTH];
  logic [PHIST_BITS-1:0] phist_q [DEPTH];
  logic [M-1:0]          meta_q  [DEPTH];
  logic                  full, mispred_resolve, push_fire, resolve_hit, drain;
  logic                  drain_taken, drain_mispred;
  tage_update_t          drain_pkt;

  assign head_idx        = head_q[IDX_W-1:0];
  assign tail_idx        = tail_q[IDX_W-1:0];
  assign full            = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign mispred_resolve = resolve_valid_i && resolve_mispred_i;
  assign push_ready_o    = !full && !flush_i && !mispred_resolve;
  assign push_fire       = push_valid_i && push_ready_o;
  assign push_idx_o      = tail_idx;
  assign count_o         = tail_q - head_q;
  assign resolve_hit     = resolve_valid_i && alloc_q[resolve_idx_i];

  // Age of the resolved slot relative to head; everything older than it survives a mispredict.
  assign res_off      = resolve_idx_i - head_idx;
  assign mispred_tail = head_q + {1'b0, res_off} + PTR_ONE;

  always_comb begin
    younger = '0;
    for (int i = 0; i < DEPTH; i++) begin
      younger[i] = (IDX_W'(i) - head_idx) > res_off;
    end
  end

`ifdef TAGE_UPDATE_QUEUE_BYPASS_EN
  logic head_res_now;
  assign head_res_now  = resolve_hit && (resolve_idx_i == head_idx);
  assign drain         = alloc_q[head_idx] && (resolved_q[head_idx] || head_res_now);
  assign drain_taken   = resolved_q[head_idx] ? taken_q[head_idx] : resolve_taken_i;
  assign drain_mispred = resolved_q[head_idx] ? mispred_q[head_idx] : resolve_mispred_i;
`else
  assign drain         = alloc_q[head_idx] && resolved_q[head_idx];
  assign drain_taken   = taken_q[head_idx];
  assign drain_mispred = mispred_q[head_idx];
`endif

  always_comb begin
    drain_pkt            = '0;
    drain_pkt.pc         = pc_q[head_idx];
    drain_pkt.taken      = drain_taken;
    drain_pkt.ghist      = ghist_q[head_idx];
    drain_pkt.phist      = phist_q[head_idx];
    {drain_pkt.pred_taken, drain_pkt.provider_taken, drain_pkt.alt_taken, drain_pkt.pred_id,
     drain_pkt.alt_id, drain_pkt.u_is_null, drain_pkt.pseudo_new_alloc} = meta_q[head_idx];
    drain_pkt.mispredict = drain_mispred;
  end

  // Push never collides with a mispredict rollback because push_ready_o is dropped that cycle.
  always_comb begin
    alloc_next    = alloc_q;
    resolved_next = resolved_q;
    tail_next     = tail_q;
    if (drain) begin
      alloc_next[head_idx] = 1'b0;
    end
    if (resolve_hit) begin
      resolved_next[resolve_idx_i] = 1'b1;
      if (resolve_mispred_i) begin
        alloc_next = alloc_next & ~younger;
        tail_next  = mispred_tail;
      end
    end
    if (push_fire) begin
      alloc_next[tail_idx]    = 1'b1;
      resolved_next[tail_idx] = 1'b0;
      tail_next               = tail_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      alloc_q        <= '0;
      resolved_q     <= '0;
      update_valid_o <= 1'b0;
      update_o       <= '0;
    end else if (flush_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      alloc_q        <= '0;
      update_valid_o <= 1'b0;
    end else begin
      alloc_q        <= alloc_next;
      resolved_q     <= resolved_next;
      tail_q         <= tail_next;
      head_q         <= drain ? head_q + PTR_ONE : head_q;
      update_valid_o <= drain;
      if (drain) begin
        update_o <= drain_pkt;
      end
    end
  end

  // Payload storage carries no reset; alloc/resolved bits decide what is meaningful.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      pc_q[tail_idx]    <= push_pc_i;
      ghist_q[tail_idx] <= push_ghist_i;
      phist_q[tail_idx] <= push_phist_i;
      meta_q[tail_idx]  <= push_meta_i;
    end
    if (resolve_hit && !flush_i) begin
      taken_q[resolve_idx_i]   <= resolve_taken_i;
      mispred_q[resolve_idx_i] <= resolve_mispred_i;
    end
  end

endmodule
